// File: rtl/sram_arbiter.sv
// Two-port SRAM controller arbiter: instruction fetch (read-only) vs data port (read/write).
// Define SRAM_ARB_RR_EN for round-robin tie breaking; otherwise the data port wins every tie.
module sram_arbiter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_req_i,
    input  logic [31:0]      if_addr_i,
    output logic [31:0]      if_rdata_o,
    output logic             if_ok_o,
    input  logic             mem_re_n_i,
    input  logic             mem_we_n_i,
    input  logic [3:0]       mem_be_n_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wdata_i,
    output logic [31:0]      mem_rdata_o,
    output logic             mem_ok_o,
    output logic             ctl_re_n_o,
    output logic             ctl_we_n_o,
    output logic [3:0]       ctl_be_n_o,
    output logic [31:0]      ctl_addr_o,
    output logic [31:0]      ctl_wdata_o,
    input  logic [31:0]      ctl_rdata_i,
    input  logic             ctl_ok_i,
    output logic [CNT_W-1:0] if_stall_cnt_o,
    output logic [CNT_W-1:0] mem_stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_t;

    state_t state_q, state_d;
    logic   mem_pend;
    logic   pick_mem;

    assign mem_pend = ~mem_re_n_i | ~mem_we_n_i;

`ifdef SRAM_ARB_RR_EN
    logic last_mem_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_mem_q <= 1'b0;
        else if (ctl_ok_i && state_q != IDLE)
            last_mem_q <= (state_q == GNT_MEM);
    end

    assign pick_mem = ~last_mem_q;
`else
    assign pick_mem = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Leaving the grant on the ok edge forces one IDLE cycle between transfers.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (if_req_i && mem_pend)
                    state_d = pick_mem ? GNT_MEM : GNT_IF;
                else if (mem_pend)
                    state_d = GNT_MEM;
                else if (if_req_i)
                    state_d = GNT_IF;
            end
            GNT_IF, GNT_MEM: begin
                if (ctl_ok_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctl_re_n_o  = 1'b1;
        ctl_we_n_o  = 1'b1;
        ctl_be_n_o  = 4'b1111;
        ctl_addr_o  = '0;
        ctl_wdata_o = '0;
        case (state_q)
            GNT_IF: begin
                ctl_re_n_o = 1'b0;
                ctl_be_n_o = 4'b0000;
                ctl_addr_o = if_addr_i;
            end
            GNT_MEM: begin
                // Both strobes low is treated as a read.
                ctl_re_n_o  = mem_re_n_i;
                ctl_we_n_o  = ~mem_re_n_i | mem_we_n_i;
                ctl_be_n_o  = mem_be_n_i;
                ctl_addr_o  = mem_addr_i;
                ctl_wdata_o = mem_wdata_i;
            end
            default: ;
        endcase
    end

    assign if_ok_o     = ctl_ok_i & (state_q == GNT_IF);
    assign mem_ok_o    = ctl_ok_i & (state_q == GNT_MEM);
    assign if_rdata_o  = if_ok_o  ? ctl_rdata_i : '0;
    assign mem_rdata_o = mem_ok_o ? ctl_rdata_i : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_stall_cnt_o  <= '0;
            mem_stall_cnt_o <= '0;
        end else begin
            if (if_req_i && !if_ok_o && if_stall_cnt_o != '1)
                if_stall_cnt_o <= if_stall_cnt_o + CNT_W'(1);
            if (mem_pend && !mem_ok_o && mem_stall_cnt_o != '1)
                mem_stall_cnt_o <= mem_stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a latency-programmable controller model and a
// grant-order scoreboard; tie expectations follow SRAM_ARB_RR_EN.
module tb_sram_arbiter;
    localparam int CNT_W = 4;
    localparam logic [31:0] MAGIC = 32'h9234_5668;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             if_req_i;
    logic [31:0]      if_addr_i;
    logic [31:0]      if_rdata_o;
    logic             if_ok_o;
    logic             mem_re_n_i, mem_we_n_i;
    logic [3:0]       mem_be_n_i;
    logic [31:0]      mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic             mem_ok_o;
    logic             ctl_re_n_o, ctl_we_n_o;
    logic [3:0]       ctl_be_n_o;
    logic [31:0]      ctl_addr_o, ctl_wdata_o;
    logic [31:0]      ctl_rdata_i = 32'hFFFF_FFFF;
    logic             ctl_ok_i = 1'b0;
    logic [CNT_W-1:0] if_stall_cnt_o, mem_stall_cnt_o;

    sram_arbiter #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ok_o(if_ok_o),
        .mem_re_n_i(mem_re_n_i), .mem_we_n_i(mem_we_n_i), .mem_be_n_i(mem_be_n_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
        .mem_ok_o(mem_ok_o),
        .ctl_re_n_o(ctl_re_n_o), .ctl_we_n_o(ctl_we_n_o), .ctl_be_n_o(ctl_be_n_o),
        .ctl_addr_o(ctl_addr_o), .ctl_wdata_o(ctl_wdata_o), .ctl_rdata_i(ctl_rdata_i),
        .ctl_ok_i(ctl_ok_i),
        .if_stall_cnt_o(if_stall_cnt_o), .mem_stall_cnt_o(mem_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_mem;
        logic [31:0] addr;
        logic        we_n;
        logic [3:0]  be_n;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   lat = 3;
    bit   spur_ok = 1'b0;
    bit   gap_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Controller model: ok after 'lat' full wait cycles of an active strobe.
    int mcnt = 0;
    always @(posedge clk_i) begin
        #2;
        if (ctl_ok_i) begin
            ctl_ok_i = 1'b0;
            ctl_rdata_i = 32'hFFFF_FFFF;
            mcnt = 0;
        end else if (!ctl_re_n_o || !ctl_we_n_o) begin
            mcnt++;
            if (mcnt > lat) begin
                ctl_ok_i = 1'b1;
                ctl_rdata_i = ctl_addr_o ^ MAGIC;
            end
        end else begin
            mcnt = 0;
            ctl_ok_i = spur_ok;
        end
    end

    // Completion monitor: order, steering, held request values and the post-ok gap.
    always @(negedge clk_i) begin
        if (rst_i) begin
            gap_chk = 1'b0;
        end else begin
            if (gap_chk) begin
                chk("gap_re_n", ctl_re_n_o, 1);
                chk("gap_we_n", ctl_we_n_o, 1);
            end
            gap_chk = if_ok_o | mem_ok_o;
            if (!if_ok_o)  chk("if_rdata_gated", if_rdata_o, 0);
            if (!mem_ok_o) chk("mem_rdata_gated", mem_rdata_o, 0);
            if (if_ok_o || mem_ok_o) begin
                chk("dual_ok", {31'd0, if_ok_o & mem_ok_o}, 0);
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("grant_port", {31'd0, mem_ok_o}, {31'd0, e.is_mem});
                    chk("ctl_addr", ctl_addr_o, e.addr);
                    chk("ctl_re_n", ctl_re_n_o, {31'd0, ~e.we_n});
                    chk("ctl_we_n", ctl_we_n_o, {31'd0, e.we_n});
                    chk("ctl_be_n", ctl_be_n_o, {28'd0, e.be_n});
                    chk("ctl_wdata", ctl_wdata_o, e.wdata);
                    chk("rdata", e.is_mem ? mem_rdata_o : if_rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_re_n_i = 1'b1; mem_we_n_i = 1'b1; mem_be_n_i = 4'hF;
        mem_addr_i = '0; mem_wdata_i = '0;
        sb.delete();
        lat = 3;
        spur_ok = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic push_if(input logic [31:0] a);
        exp_t e;
        e.is_mem = 1'b0; e.addr = a; e.we_n = 1'b1; e.be_n = 4'h0;
        e.wdata = '0; e.rdata = a ^ MAGIC;
        sb.push_back(e);
    endtask

    task automatic push_mem(input logic re_n, input logic we_n, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.is_mem = 1'b1; e.addr = a; e.we_n = ~re_n | we_n; e.be_n = be;
        e.wdata = wd; e.rdata = a ^ MAGIC;
        sb.push_back(e);
    endtask

    // Issue requests in the same cycle; each requester drops the cycle after its ok.
    task automatic run(input bit do_if, input logic [31:0] ia,
                       input bit do_mem, input logic re_n, input logic we_n,
                       input logic [3:0] be, input logic [31:0] ma, input logic [31:0] wd,
                       input bit mem_first);
        bit done_if, done_mem, hit_if, hit_mem;
        @(posedge clk_i); #1;
        if (do_if) begin if_req_i = 1'b1; if_addr_i = ia; end
        if (do_mem) begin
            mem_re_n_i = re_n; mem_we_n_i = we_n; mem_be_n_i = be;
            mem_addr_i = ma; mem_wdata_i = wd;
        end
        if (mem_first) begin
            if (do_mem) push_mem(re_n, we_n, be, ma, wd);
            if (do_if)  push_if(ia);
        end else begin
            if (do_if)  push_if(ia);
            if (do_mem) push_mem(re_n, we_n, be, ma, wd);
        end
        done_if = !do_if;
        done_mem = !do_mem;
        for (int c = 0; c < 200 && !(done_if && done_mem); c++) begin
            @(negedge clk_i);
            hit_if = if_ok_o;
            hit_mem = mem_ok_o;
            @(posedge clk_i); #1;
            if (hit_if)  begin if_req_i = 1'b0; if_addr_i = '0; done_if = 1'b1; end
            if (hit_mem) begin mem_re_n_i = 1'b1; mem_we_n_i = 1'b1; done_mem = 1'b1; end
        end
        chk("run_timeout", {31'd0, done_if && done_mem}, 1);
    endtask

    task automatic wait_if_ok();
        bit hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk_i);
            hit = if_ok_o;
        end
        chk("if_ok_timeout", {31'd0, hit}, 1);
        @(posedge clk_i); #1;
    endtask

    initial begin
        bit rr_mem_first;
        do_reset();
        // Reset/IDLE values
        rst_i = 1'b1; #1;
        chk("rst_re_n", ctl_re_n_o, 1);
        chk("rst_we_n", ctl_we_n_o, 1);
        chk("rst_be_n", ctl_be_n_o, 32'hF);
        chk("rst_addr", ctl_addr_o, 0);
        chk("rst_wdata", ctl_wdata_o, 0);
        chk("rst_oks", {30'd0, if_ok_o, mem_ok_o}, 0);
        chk("rst_cnts", {if_stall_cnt_o, mem_stall_cnt_o}, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Single fetch
        run(1'b1, 32'h8000_0010, 1'b0, 1'b1, 1'b1, 4'hF, 0, 0, 1'b0);
        chk("fetch_if_stall", if_stall_cnt_o, 4);
        chk("fetch_mem_stall", mem_stall_cnt_o, 0);

        // Data write, then a read with both strobes low
        do_reset();
        run(1'b0, 0, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h8040_0000, 32'hDEAD_BEEF, 1'b1);
        chk("write_mem_stall", mem_stall_cnt_o, 4);
        chk("post_write_we_n", ctl_we_n_o, 1);
        run(1'b0, 0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h8040_0010, 32'h1111_2222, 1'b1);

        // Tie from reset: mem first in both modes
        do_reset();
        run(1'b1, 32'h8000_0100, 1'b1, 1'b0, 1'b1, 4'h0, 32'h8040_0100, 0, 1'b1);
        chk("tie_if_stall", if_stall_cnt_o, 9);
        chk("tie_mem_stall", mem_stall_cnt_o, 4);

        // After a mem-only completion the next tie goes to IF under round-robin
`ifdef SRAM_ARB_RR_EN
        rr_mem_first = 1'b0;
`else
        rr_mem_first = 1'b1;
`endif
        run(1'b0, 0, 1'b1, 1'b0, 1'b1, 4'h0, 32'h8040_0200, 0, 1'b1);
        run(1'b1, 32'h8000_0300, 1'b1, 1'b1, 1'b0, 4'b0011, 32'h8040_0300, 32'hCAFE_F00D,
            rr_mem_first);

        // Back-to-back fetches with the request held and the address changed
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 32'h8000_0400; push_if(32'h8000_0400);
        wait_if_ok();
        chk("b2b_idle_re_n", ctl_re_n_o, 1);
        if_addr_i = 32'h8000_0404; push_if(32'h8000_0404);
        wait_if_ok();
        if_req_i = 1'b0;

        // Spurious ok while idle
        @(posedge clk_i); #1 spur_ok = 1'b1;
        @(negedge clk_i);
        chk("spur_ctl_ok", ctl_ok_i, 1);
        chk("spur_oks", {30'd0, if_ok_o, mem_ok_o}, 0);
        spur_ok = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 chk("sb_drained", sb.size(), 0);

        // Async reset mid data grant
        do_reset();
        lat = 50;
        @(posedge clk_i); #1;
        mem_re_n_i = 1'b0; mem_addr_i = 32'h8040_0500;
        repeat (2) @(posedge clk_i);
        #1 chk("mid_grant_re_n", ctl_re_n_o, 0);
        #3 rst_i = 1'b1;
        #1;
        chk("arst_re_n", ctl_re_n_o, 1);
        chk("arst_be_n", ctl_be_n_o, 32'hF);
        chk("arst_addr", ctl_addr_o, 0);
        chk("arst_mem_ok", mem_ok_o, 0);
        chk("arst_cnt", mem_stall_cnt_o, 0);

        // Stall counter saturation
        do_reset();
        lat = 50;
        @(posedge clk_i); #1 if_req_i = 1'b1; if_addr_i = 32'h8000_0600;
        repeat (20) @(posedge clk_i);
        #1 chk("sat_if_stall", if_stall_cnt_o, 15);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller between the instruction-fetch port (read-only) and the data-memory port (read/write). Sits between the CPU pipeline and the SRAM controller's CPU-side interface. Grants one requester at a time and holds the granted request stable until the controller's one-cycle completion pulse. Steers the completion and read data back to the owner and keeps per-port stall counters for profiling.

## Interface
- Parameters:
- CNT_W, 32, width of each stall counter (saturating)
- Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch read request, held until if_ok_o
- if_addr_i  in  32  fetch byte address
- if_rdata_o  out  32  fetch read data, valid while if_ok_o=1
- if_ok_o  out  1  fetch completion pulse
- mem_re_n_i  in  1  data read strobe, active-low
- mem_we_n_i  in  1  data write strobe, active-low
- mem_be_n_i  in  4  data byte enables, active-low
- mem_addr_i  in  32  data byte address
- mem_wdata_i  in  32  data write data
- mem_rdata_o  out  32  data read data, valid while mem_ok_o=1
- mem_ok_o  out  1  data completion pulse
- ctl_re_n_o / ctl_we_n_o  out  1 each  controller read/write strobes, active-low
- ctl_be_n_o  out  4  controller byte enables
- ctl_addr_o / ctl_wdata_o  out  32 each  controller address / write data
- ctl_rdata_i  in  32  controller read data
- ctl_ok_i  in  1  controller one-cycle completion pulse
- if_stall_cnt_o / mem_stall_cnt_o  out  CNT_W each  stall-cycle counters

## Operation
- mem request pending = ~mem_re_n_i | ~mem_we_n_i. If both strobes are low, the request is a read; ctl_we_n_o stays 1.
- FSM states: IDLE, GNT_IF, GNT_MEM.
- IDLE: no pending request -> stay. Exactly one pending -> grant that port. Both pending -> priority rule (see Configuration).
- GNT_x: ctl_* outputs are a mux of port x inputs. Strobes come from port x: for IF, re_n=0 and we_n=1, be_n=4'b0000, wdata=0. ctl_ok_i=1 -> IDLE. Otherwise stay.
- In IDLE every ctl_* output is inactive: re_n=1, we_n=1, be_n=4'b1111, addr=0, wdata=0.
- x_ok_o = ctl_ok_i & (state==GNT_x), combinational. x_rdata_o = ctl_rdata_i when x_ok_o=1, else 0.
- The requester drops or changes its request in the cycle after its ok. The arbiter ignores request inputs in the ok cycle, because it leaves GNT_x on that edge.
- Stall counters increment by 1 each cycle the port's request is pending and its ok is 0. They saturate at all-ones and never wrap.
- ctl_ok_i while in IDLE: ignored, no ok output.
- Reset (async): state=IDLE, all ctl strobes inactive, ok outputs 0, stall counters 0, RR pointer = IF-last. Reset mid-grant abandons the transfer; no ok is issued.

## Timing
- Request seen at edge T while in IDLE -> grant state from T. Controller strobes are asserted during cycle T..T+1 (one registered decision cycle).
- Completion: x_ok_o is in the same cycle as ctl_ok_i, zero added latency.
- After each completion there is at least one IDLE cycle with inactive strobes before the next grant. This keeps the controller from re-launching a finished request.
- Minimum back-to-back period is controller latency + 1 cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin. A 1-bit last-granted register updates on every completion, and on a tie the port not granted last wins.
- SRAM_ARB_RR_EN undefined: fixed priority. mem wins every tie and the RR register is not built. IF may starve under continuous mem traffic.

## Test plan
- Single fetch: if_req_i=1, addr=0x80000010. Controller model returns ok after 3 cycles with rdata 0x12345678 -> ctl_re_n_o=0 with addr 0x80000010 during the grant, if_ok_o=1 with if_rdata_o=0x12345678 for 1 cycle, if_stall_cnt_o=4 (3 wait cycles + decision cycle).
- Data write: mem_we_n_i=0, be_n=4'b1100, addr 0x80400000, wdata 0xdeadbeef -> controller sees the same values held stable, mem_ok_o pulses once, and ctl strobes return high the next cycle.
- Simultaneous requests, back to back, macro undefined -> mem granted first, then IF. With SRAM_ARB_RR_EN defined, after a mem completion the next tie goes to IF and the one after goes to mem.
- Gap check: two consecutive fetches -> at least 1 cycle with ctl_re_n_o=1 between the first if_ok_o and the second grant.
- Async reset during GNT_MEM -> outputs go to reset values immediately without waiting for a clock edge, no mem_ok_o, counters 0.
- Saturation with CNT_W=4 and IF held pending for 20 cycles -> if_stall_cnt_o stops at 15.
